// File: rtl/seven_segment_to_binary.sv
// Resynchronizes seven externally driven segment lines, waits for a pattern to stay
// stable for STABLE_CYCLES samples, then decodes it back to a hex nibble with strobes.
module seven_segment_to_binary #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_segment_a,
  input  logic       i_segment_b,
  input  logic       i_segment_c,
  input  logic       i_segment_d,
  input  logic       i_segment_e,
  input  logic       i_segment_f,
  input  logic       i_segment_g,
  output logic [3:0] o_binary_num,
  output logic       o_dv,
  output logic       o_invalid,
  output logic       o_blank
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] RUN_TARGET = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] RUN_ONE    = CW'(1);

  typedef enum logic {
    ST_WAIT,
    ST_LOCKED
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [6:0]      r_meta;
  logic [6:0]      r_sync;
  logic [6:0]      r_prev;
  logic [1:0]      r_fill;
  logic            r_prev_vld;
  logic [CW-1:0]   r_run;
  logic [CW-1:0]   run_cur;
  logic            same;
  logic            accept;
  logic            dec_valid;
  logic [3:0]      dec_value;

  // The fill flags keep reset-cleared flops from counting as real samples, so the
  // first accept after reset takes the full latency like any other.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta     <= '0;
      r_sync     <= '0;
      r_prev     <= '0;
      r_fill     <= '0;
      r_prev_vld <= 1'b0;
      r_run      <= '0;
      state_q    <= ST_WAIT;
    end else begin
      r_meta     <= {i_segment_a, i_segment_b, i_segment_c, i_segment_d,
                     i_segment_e, i_segment_f, i_segment_g};
      r_sync     <= r_meta;
      r_prev     <= r_sync;
      r_fill     <= {r_fill[0], 1'b1};
      r_prev_vld <= r_fill[1];
      r_run      <= run_cur;
      state_q    <= state_d;
    end
  end

  // run_cur is the length of the identical-sample run ending with the current r_sync.
  always_comb begin
    same    = r_fill[1] && r_prev_vld && (r_sync == r_prev);
    run_cur = '0;
    if (r_fill[1]) begin
      if (same) begin
        run_cur = (r_run == RUN_TARGET) ? RUN_TARGET : r_run + RUN_ONE;
      end else begin
        run_cur = RUN_ONE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    if (!same) begin
      state_d = ST_WAIT;
    end else if (state_q == ST_WAIT && run_cur == RUN_TARGET) begin
      accept  = 1'b1;
      state_d = ST_LOCKED;
    end
  end

  always_comb begin
    dec_valid = 1'b1;
    dec_value = 4'h0;
    case (r_sync)
      7'h7E: dec_value = 4'h0;
      7'h30: dec_value = 4'h1;
      7'h6D: dec_value = 4'h2;
      7'h79: dec_value = 4'h3;
      7'h33: dec_value = 4'h4;
      7'h5B: dec_value = 4'h5;
      7'h5F: dec_value = 4'h6;
      7'h70: dec_value = 4'h7;
      7'h7F: dec_value = 4'h8;
      7'h7B: dec_value = 4'h9;
      7'h77: dec_value = 4'hA;
      7'h1F: dec_value = 4'hB;
      7'h4E: dec_value = 4'hC;
      7'h3D: dec_value = 4'hD;
      7'h4F: dec_value = 4'hE;
      7'h47: dec_value = 4'hF;
      default: dec_valid = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_binary_num <= 4'h0;
      o_dv         <= 1'b0;
      o_invalid    <= 1'b0;
      o_blank      <= 1'b0;
    end else begin
      o_dv      <= accept && dec_valid;
      o_invalid <= accept && !dec_valid && (r_sync != 7'h00);
      if (accept && dec_valid) begin
        o_binary_num <= dec_value;
        o_blank      <= 1'b0;
      end else if (accept && r_sync == 7'h00) begin
        o_blank <= 1'b1;
      end
    end
  end

endmodule
